// File: rtl/random_pkg.sv
// Shared types and defaults for the PRBS checker and its generator bench.
package random_pkg;

    typedef enum logic {SEARCH, LOCKED} state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_LOCK_CNT = 8;
    localparam int DEF_LOSS_CNT = 4;
    localparam int DEF_ERR_W    = 16;

    // x^4 + x^3 + 1 : b[n] = b[n-4] ^ b[n-1], period 15
    localparam logic [2:0] CODE_X4_X3_1 = 3'b001;

endpackage

// File: rtl/random_predict.sv
// Next-bit prediction of the tap-selectable LFSR from its bit history.
module random_predict #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] hist,
    input  logic [WIDTH-2:0] code,
    output logic             pred
);

    // hist[0] is b[n-1]; code[k-1] selects b[n-k]; b[n-WIDTH] always taps
    assign pred = hist[WIDTH-1] ^ (^(code & hist[WIDTH-2:0]));

endmodule

// File: rtl/random_checker.sv
// Self-synchronising serial PRBS checker with leaky loss-of-lock detection.
// Define RANDOM_CHECKER_STATS_EN to add the bit_cnt output.
module random_checker
    import random_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOSS_CNT = DEF_LOSS_CNT,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             Cp,
    input  logic             R,
    input  logic             din,
    input  logic             din_valid,
    input  logic [WIDTH-2:0] code,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_cnt
`ifdef RANDOM_CHECKER_STATS_EN
    ,
    output logic [ERR_W-1:0] bit_cnt
`endif
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH);
    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [7:0] LOSS_TGT = 8'(LOSS_CNT);

    state_t            state;
    logic [WIDTH-1:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [7:0]        good;
    logic [7:0]        bad;
    logic              pred;
    logic              match;
    logic              err_hit;
    logic [ERR_W-1:0]  err_next;

    random_predict #(.WIDTH(WIDTH)) u_pred (
        .hist (hist),
        .code (code),
        .pred (pred)
    );

    assign match   = (din == pred);
    assign err_hit = din_valid && (state == LOCKED) && !match;

    // Clear first, then count the current bit, so a simultaneous error survives
    always_comb begin
        err_next = clr_cnt ? '0 : err_cnt;
        if (err_hit && !(&err_next))
            err_next = err_next + 1'b1;
    end

    always_ff @(posedge Cp) begin
        if (R) begin
            state   <= SEARCH;
            hist    <= '0;
            fill    <= '0;
            good    <= '0;
            bad     <= '0;
            locked  <= 1'b0;
            bit_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            bit_err <= err_hit;
            err_cnt <= err_next;
            if (din_valid) begin
                case (state)
                    SEARCH: begin
                        hist <= {hist[WIDTH-2:0], din};
                        if (fill != FILL_MAX) begin
                            fill <= fill + 1'b1;
                        end else if (!match) begin
                            good <= '0;
                        end else if (hist != '0) begin
                            // an all-zero history trivially matches a stuck line
                            if (good == LOCK_TGT - 8'd1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                good   <= '0;
                                bad    <= '0;
                            end else begin
                                good <= good + 8'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        // free-run on the prediction so a line error is not re-seeded
                        hist <= {hist[WIDTH-2:0], pred};
                        if (!match) begin
                            if (bad == LOSS_TGT - 8'd1) begin
                                state  <= SEARCH;
                                locked <= 1'b0;
                                fill   <= '0;
                                good   <= '0;
                                bad    <= '0;
                            end else begin
                                bad <= bad + 8'd1;
                            end
                        end else if (bad != '0) begin
                            bad <= bad - 8'd1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

`ifdef RANDOM_CHECKER_STATS_EN
    logic [ERR_W-1:0] bit_next;

    always_comb begin
        bit_next = clr_cnt ? '0 : bit_cnt;
        if (din_valid && (state == LOCKED) && !(&bit_next))
            bit_next = bit_next + 1'b1;
    end

    always_ff @(posedge Cp) begin
        if (R)
            bit_cnt <= '0;
        else
            bit_cnt <= bit_next;
    end
`endif

endmodule

// File: tb/tb_random_checker.sv
// Directed bench for random_checker using the x^4+x^3+1 sequence 000111101011001.
module tb_random_checker;
    import random_pkg::*;

    logic        Cp;
    logic        R;
    logic        din;
    logic        din_valid;
    logic [2:0]  code;
    logic        clr_cnt;
    logic        locked;
    logic        bit_err;
    logic [15:0] err_cnt;
`ifdef RANDOM_CHECKER_STATS_EN
    logic [15:0] bit_cnt;
`endif

    int checks = 0;
    int errors = 0;

    random_checker dut (
        .Cp        (Cp),
        .R         (R),
        .din       (din),
        .din_valid (din_valid),
        .code      (code),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .bit_err   (bit_err),
        .err_cnt   (err_cnt)
`ifdef RANDOM_CHECKER_STATS_EN
        ,
        .bit_cnt   (bit_cnt)
`endif
    );

    initial Cp = 1'b0;
    always #5 Cp = ~Cp;

    function automatic logic prbs(input int i);
        logic [14:0] p;
        p = 15'b100110101111000;  // p[0] is the first bit sent
        return p[i % 15];
    endfunction

    // Drive one cycle; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic b, input logic v);
        din = b;
        din_valid = v;
        @(posedge Cp);
        #1;
    endtask

    task automatic pulse_reset();
        R = 1'b1;
        step(1'b1, 1'b1);
        R = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++;
        if (bit_err !== 1'b0) begin errors++; $display("FAIL reset_bit_err: got %b want 0", bit_err); end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
`ifdef RANDOM_CHECKER_STATS_EN
        checks++;
        if (bit_cnt !== 16'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
`endif
    endtask

    // 4 fill bits + 8 qualified matches: lock on stream bit 11.
    task automatic test_lock();
        for (int n = 0; n < 12; n++) begin
            step(prbs(n), 1'b1);
            checks++;
            if (locked !== (n == 11)) begin errors++; $display("FAIL lock_timing bit %0d: got %b want %b", n, locked, (n == 11)); end
            checks++;
            if (bit_err !== 1'b0) begin errors++; $display("FAIL lock_bit_err bit %0d: got %b want 0", n, bit_err); end
        end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL lock_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_single_error();
        for (int n = 12; n < 30; n++) begin
            step((n == 20) ? ~prbs(n) : prbs(n), 1'b1);
            checks++;
            if (bit_err !== (n == 20)) begin errors++; $display("FAIL single_bit_err bit %0d: got %b want %b", n, bit_err, (n == 20)); end
            checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL single_locked bit %0d: got %b want 1", n, locked); end
        end
        checks++;
        if (err_cnt !== 16'd1) begin errors++; $display("FAIL single_err_cnt: got %0d want 1", err_cnt); end
`ifdef RANDOM_CHECKER_STATS_EN
        checks++;
        if (bit_cnt !== 16'd18) begin errors++; $display("FAIL single_bit_cnt: got %0d want 18", bit_cnt); end
`endif
    endtask

    task automatic test_clear();
        clr_cnt = 1'b1;
        step(~prbs(30), 1'b1);  // clear + counted mismatch
        checks++;
        if (err_cnt !== 16'd1) begin errors++; $display("FAIL clr_with_err: got %0d want 1", err_cnt); end
        step(prbs(31), 1'b1);   // clear alone
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL clr_alone: got %0d want 0", err_cnt); end
        clr_cnt = 1'b0;
        step(~prbs(32), 1'b1);
        checks++;
        if (err_cnt !== 16'd1) begin errors++; $display("FAIL clr_then_err: got %0d want 1", err_cnt); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL clr_locked: got %b want 1", locked); end
`ifdef RANDOM_CHECKER_STATS_EN
        checks++;
        if (bit_cnt !== 16'd2) begin errors++; $display("FAIL clr_bit_cnt: got %0d want 2", bit_cnt); end
`endif
    endtask

    // bad is 1 on entry; 3 good bits drain it, then 4 inverted bits cause loss.
    task automatic test_loss();
        for (int n = 33; n < 36; n++) step(prbs(n), 1'b1);
        for (int n = 36; n < 40; n++) begin
            step(~prbs(n), 1'b1);
            checks++;
            if (bit_err !== 1'b1) begin errors++; $display("FAIL loss_bit_err bit %0d: got %b want 1", n, bit_err); end
            checks++;
            if (locked !== (n != 39)) begin errors++; $display("FAIL loss_locked bit %0d: got %b want %b", n, locked, (n != 39)); end
        end
        checks++;
        if (err_cnt !== 16'd5) begin errors++; $display("FAIL loss_err_cnt: got %0d want 5", err_cnt); end
        // the complement violates b[n]=b[n-4]^b[n-1] on every bit, so search never qualifies
        for (int n = 40; n < 60; n++) begin
            step(~prbs(n), 1'b1);
            checks++;
            if (locked !== 1'b0 || bit_err !== 1'b0) begin
                errors++;
                $display("FAIL inverted_search bit %0d: got locked=%b bit_err=%b want 0 0", n, locked, bit_err);
            end
        end
        checks++;
        if (err_cnt !== 16'd5) begin errors++; $display("FAIL inverted_err_cnt: got %0d want 5", err_cnt); end
    endtask

    task automatic test_reset_locked();
        pulse_reset();
        for (int n = 0; n < 12; n++) begin
            step(prbs(n), 1'b1);
            checks++;
            if (locked !== (n == 11)) begin errors++; $display("FAIL relock1 bit %0d: got %b want %b", n, locked, (n == 11)); end
        end
        step(~prbs(12), 1'b1);
        checks++;
        if (bit_err !== 1'b1 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL prereset_err: got bit_err=%b err_cnt=%0d want 1 1", bit_err, err_cnt);
        end
        pulse_reset();
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL midlock_reset_locked: got %b want 0", locked); end
        checks++;
        if (bit_err !== 1'b0) begin errors++; $display("FAIL midlock_reset_bit_err: got %b want 0", bit_err); end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL midlock_reset_err_cnt: got %0d want 0", err_cnt); end
        for (int n = 0; n < 12; n++) begin
            step(prbs(n + 5), 1'b1);
            checks++;
            if (locked !== (n == 11)) begin errors++; $display("FAIL relock2 bit %0d: got %b want %b", n, locked, (n == 11)); end
        end
    endtask

    task automatic test_stuck();
        pulse_reset();
        for (int n = 0; n < 100; n++) begin
            step(1'b0, 1'b1);
            checks++;
            if (locked !== 1'b0) begin errors++; $display("FAIL stuck_locked bit %0d: got %b want 0", n, locked); end
        end
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL stuck_err_cnt: got %0d want 0", err_cnt); end
    endtask

    task automatic test_valid_gaps();
        pulse_reset();
        for (int n = 0; n < 12; n++) begin
            step(prbs(n), 1'b1);
            checks++;
            if (locked !== (n == 11)) begin errors++; $display("FAIL gap_valid bit %0d: got %b want %b", n, locked, (n == 11)); end
            step(~prbs(n + 1), 1'b0);
            checks++;
            if (locked !== (n == 11) || bit_err !== 1'b0) begin
                errors++;
                $display("FAIL gap_invalid after bit %0d: got locked=%b bit_err=%b want %b 0", n, locked, bit_err, (n == 11));
            end
        end
        step(~prbs(12), 1'b1);
        checks++;
        if (bit_err !== 1'b1 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL gap_err: got bit_err=%b err_cnt=%0d want 1 1", bit_err, err_cnt);
        end
        step(~prbs(13), 1'b0);
        checks++;
        if (bit_err !== 1'b0 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL gap_err_hold: got bit_err=%b err_cnt=%0d want 0 1", bit_err, err_cnt);
        end
        step(prbs(13), 1'b1);
        checks++;
        if (bit_err !== 1'b0 || err_cnt !== 16'd1 || locked !== 1'b1) begin
            errors++;
            $display("FAIL gap_resume: got bit_err=%b err_cnt=%0d locked=%b want 0 1 1", bit_err, err_cnt, locked);
        end
    endtask

    initial begin
        R = 1'b1;
        din = 1'b0;
        din_valid = 1'b0;
        code = CODE_X4_X3_1;
        clr_cnt = 1'b0;
        repeat (2) @(posedge Cp);
        #1;
        test_reset();
        test_lock();
        test_single_error();
        test_clear();
        test_loss();
        test_reset_locked();
        test_stuck();
        test_valid_gaps();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
